// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit: ARM condition codes,
// NZCV flag layout and the context-select width helper.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // A single context still needs a 1-bit select port.
  function automatic int ctx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator; shared with the branch unit.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex
);

  logic ge;

  always_comb begin
    ge      = (flags.n == flags.v);
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ:      cond_ex = flags.z;
      NE:      cond_ex = ~flags.z;
      CS:      cond_ex = flags.c;
      CC:      cond_ex = ~flags.c;
      MI:      cond_ex = flags.n;
      PL:      cond_ex = ~flags.n;
      VS:      cond_ex = flags.v;
      VC:      cond_ex = ~flags.v;
      HI:      cond_ex = flags.c & ~flags.z;
      LS:      cond_ex = ~flags.c | flags.z;
      GE:      cond_ex = ge;
      LT:      cond_ex = ~ge;
      GT:      cond_ex = ~flags.z & ge;
      LE:      cond_ex = flags.z | ~ge;
      AL:      cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_pipe.sv
// Execute-stage conditional logic: banked NZCV flags with exception save/restore,
// gated write controls (optionally registered) and executed/skipped counters.
module condlogic_pipe
  import cond_pkg::*;
#(
  parameter int NUM_CTX = 2,
  parameter int OUT_REG = 1,
  parameter int CNT_W   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid,
  input  logic                            stall,
  input  logic                            flush,
  input  logic [ctx_width(NUM_CTX)-1:0]   ctx_sel,
  input  logic [3:0]                      Cond,
  input  logic [3:0]                      ALUFlags,
  input  logic [1:0]                      FlagW,
  input  logic                            PCS,
  input  logic                            RegW,
  input  logic                            MemW,
  input  logic                            exc_entry,
  input  logic                            exc_return,
  output logic                            PCSrc,
  output logic                            RegWrite,
  output logic                            MemWrite,
  output logic                            CondEx,
  output logic                            cond_undef,
  output logic [3:0]                      Flags,
  output logic [CNT_W-1:0]                exec_cnt,
  output logic [CNT_W-1:0]                skip_cnt
);

  localparam int CTX_W  = ctx_width(NUM_CTX);
  localparam int BANK_N = 1 << CTX_W;

  flags_t           bank [BANK_N];
  flags_t           saved;
  flags_t           cur;
  logic [CTX_W-1:0] act_idx;
  logic             cond_ex;
  logic             live;
  logic             go;
  logic             undef;
  logic [1:0]       flag_write;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] skip_q;

  // Out-of-range selects fall back to context 0 so unused bank slots stay idle.
  always_comb begin
    act_idx = '0;
    if (32'(ctx_sel) < 32'(NUM_CTX)) act_idx = ctx_sel;
  end

  assign cur = bank[act_idx];

  cond_eval u_eval (
    .cond    (Cond),
    .flags   (cur),
    .cond_ex (cond_ex)
  );

  assign live       = valid & ~flush & ~stall;
  assign go         = live & cond_ex;
  assign flag_write = FlagW & {2{go}};
  assign undef      = valid & (Cond == 4'hF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BANK_N; i++) bank[i] <= '0;
      saved  <= '0;
      exec_q <= '0;
      skip_q <= '0;
    end else if (!stall) begin
      if (exc_entry) saved <= cur;
      // Restore takes priority over a same-cycle flag write.
      if (exc_return) begin
        bank[act_idx] <= saved;
      end else begin
        if (flag_write[1]) begin
          bank[act_idx].n <= ALUFlags[FLAG_N];
          bank[act_idx].z <= ALUFlags[FLAG_Z];
        end
        if (flag_write[0]) begin
          bank[act_idx].c <= ALUFlags[FLAG_C];
          bank[act_idx].v <= ALUFlags[FLAG_V];
        end
      end
      if (go)               exec_q <= exec_q + CNT_W'(1);
      if (live && !cond_ex) skip_q <= skip_q + CNT_W'(1);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [3:0] out_q;

      always_ff @(posedge clk) begin
        if (!reset) begin
          out_q <= '0;
        end else if (!stall) begin
          if (flush) out_q <= '0;
          else       out_q <= {PCS & go, RegW & go, MemW & go, undef};
        end
      end

      assign {PCSrc, RegWrite, MemWrite, cond_undef} = out_q;
    end else begin : g_out_comb
      assign PCSrc      = PCS & go;
      assign RegWrite   = RegW & go;
      assign MemWrite   = MemW & go;
      assign cond_undef = undef;
    end
  endgenerate

  assign CondEx   = cond_ex;
  assign Flags    = cur;
  assign exec_cnt = exec_q;
  assign skip_cnt = skip_q;

endmodule

// File: tb/tb_condlogic_pipe.sv
// Directed bench: u1 is the default build (registered outputs), u2 is a
// 3-context, combinational-output, 4-bit-counter build driven in parallel.
module tb_condlogic_pipe;
  import cond_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, valid, stall, flush, ctx_sel, oor;
  logic [1:0] ctx_sel2;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, exc_entry, exc_return;

  logic        u1_PCSrc, u1_RegWrite, u1_MemWrite, u1_CondEx, u1_cond_undef;
  logic [3:0]  u1_Flags;
  logic [15:0] u1_exec, u1_skip;
  logic        u2_PCSrc, u2_RegWrite, u2_MemWrite, u2_CondEx, u2_cond_undef;
  logic [3:0]  u2_Flags;
  logic [3:0]  u2_exec, u2_skip;

  int total = 0;
  int bad   = 0;

  assign ctx_sel2 = oor ? 2'b11 : {1'b0, ctx_sel};

  condlogic_pipe #(.NUM_CTX(2), .OUT_REG(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .valid(valid), .stall(stall), .flush(flush),
    .ctx_sel(ctx_sel), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .exc_entry(exc_entry), .exc_return(exc_return),
    .PCSrc(u1_PCSrc), .RegWrite(u1_RegWrite), .MemWrite(u1_MemWrite), .CondEx(u1_CondEx),
    .cond_undef(u1_cond_undef), .Flags(u1_Flags), .exec_cnt(u1_exec), .skip_cnt(u1_skip)
  );

  condlogic_pipe #(.NUM_CTX(3), .OUT_REG(0), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .valid(valid), .stall(stall), .flush(flush),
    .ctx_sel(ctx_sel2), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .exc_entry(exc_entry), .exc_return(exc_return),
    .PCSrc(u2_PCSrc), .RegWrite(u2_RegWrite), .MemWrite(u2_MemWrite), .CondEx(u2_CondEx),
    .cond_undef(u2_cond_undef), .Flags(u2_Flags), .exec_cnt(u2_exec), .skip_cnt(u2_skip)
  );

  task automatic idle();
    valid = 0; stall = 0; flush = 0; Cond = AL; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 0; RegW = 0; MemW = 0; exc_entry = 0; exc_return = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    reset = 0; valid = 1; FlagW = 2'b11; ALUFlags = 4'hF; PCS = 1; RegW = 1;
    @(posedge clk); #1;
    cyc();
    total++; if (u1_Flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h want=0", u1_Flags); end
    total++; if (u1_exec !== 16'd0) begin bad++; $display("FAIL reset_exec got=%0d want=0", u1_exec); end
    total++; if (u1_skip !== 16'd0) begin bad++; $display("FAIL reset_skip got=%0d want=0", u1_skip); end
    total++; if ({u1_PCSrc, u1_RegWrite, u1_MemWrite, u1_cond_undef} !== 4'b0000) begin
      bad++; $display("FAIL reset_outreg got=%b want=0000", {u1_PCSrc, u1_RegWrite, u1_MemWrite, u1_cond_undef});
    end
    reset = 1;
  endtask

  task automatic test_cond_fail();
    valid = 1; Cond = EQ; RegW = 1; #1;
    total++; if (u1_CondEx !== 1'b0) begin bad++; $display("FAIL eq_condex got=%b want=0", u1_CondEx); end
    total++; if (u2_RegWrite !== 1'b0) begin bad++; $display("FAIL eq_comb_regwrite got=%b want=0", u2_RegWrite); end
    cyc();
    total++; if (u1_RegWrite !== 1'b0) begin bad++; $display("FAIL eq_regwrite got=%b want=0", u1_RegWrite); end
    total++; if (u1_skip !== 16'd1) begin bad++; $display("FAIL eq_skip got=%0d want=1", u1_skip); end
    total++; if (u1_exec !== 16'd0) begin bad++; $display("FAIL eq_exec got=%0d want=0", u1_exec); end
  endtask

  task automatic test_flag_halves();
    valid = 1; Cond = AL; RegW = 1; ALUFlags = 4'b0100; FlagW = 2'b10; #1;
    total++; if (u2_RegWrite !== 1'b1) begin bad++; $display("FAIL al_comb_regwrite got=%b want=1", u2_RegWrite); end
    cyc();
    total++; if (u1_Flags !== 4'b0100) begin bad++; $display("FAIL nz_write got=%b want=0100", u1_Flags); end
    total++; if (u1_RegWrite !== 1'b1) begin bad++; $display("FAIL al_regwrite got=%b want=1", u1_RegWrite); end
    total++; if (u1_exec !== 16'd1) begin bad++; $display("FAIL al_exec got=%0d want=1", u1_exec); end
    valid = 1; Cond = EQ; MemW = 1; #1;
    total++; if (u1_CondEx !== 1'b1) begin bad++; $display("FAIL eq_after_z got=%b want=1", u1_CondEx); end
    total++; if (u2_MemWrite !== 1'b1) begin bad++; $display("FAIL eq_comb_memwrite got=%b want=1", u2_MemWrite); end
    cyc();
    total++; if (u1_MemWrite !== 1'b1) begin bad++; $display("FAIL eq_memwrite got=%b want=1", u1_MemWrite); end
    total++; if (u1_exec !== 16'd2) begin bad++; $display("FAIL eq_exec got=%0d want=2", u1_exec); end
  endtask

  task automatic test_half_write();
    logic [15:0] tab;
    valid = 1; Cond = AL; ALUFlags = 4'hF; FlagW = 2'b01;
    cyc();
    total++; if (u1_Flags !== 4'b0111) begin bad++; $display("FAIL cv_write got=%b want=0111", u1_Flags); end
    valid = 1; Cond = GE; #1;
    total++; if (u1_CondEx !== 1'b0) begin bad++; $display("FAIL ge_n0v1 got=%b want=0", u1_CondEx); end
    cyc();
    total++; if (u1_skip !== 16'd2) begin bad++; $display("FAIL ge_skip got=%0d want=2", u1_skip); end
    tab = 16'h6A65;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i); #1;
      total++; if (u1_CondEx !== tab[i]) begin bad++; $display("FAIL table0111 cond=%0d got=%b want=%b", i, u1_CondEx, tab[i]); end
    end
    idle();
  endtask

  task automatic test_exception();
    logic [15:0] tab;
    ctx_sel = 1; #1;
    total++; if (u1_Flags !== 4'h0) begin bad++; $display("FAIL ctx1_init got=%b want=0000", u1_Flags); end
    valid = 1; Cond = AL; FlagW = 2'b11; ALUFlags = 4'b1001;
    cyc();
    total++; if (u1_Flags !== 4'b1001) begin bad++; $display("FAIL ctx1_set got=%b want=1001", u1_Flags); end
    ctx_sel = 0; #1;
    total++; if (u1_Flags !== 4'b0111) begin bad++; $display("FAIL ctx0_kept got=%b want=0111", u1_Flags); end
    ctx_sel = 1;
    tab = 16'h565A;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i); #1;
      total++; if (u1_CondEx !== tab[i]) begin bad++; $display("FAIL table1001 cond=%0d got=%b want=%b", i, u1_CondEx, tab[i]); end
    end
    idle();
    exc_entry = 1; valid = 1; Cond = AL; FlagW = 2'b11; ALUFlags = 4'h0;
    cyc();
    total++; if (u1_Flags !== 4'h0) begin bad++; $display("FAIL entry_ctx1 got=%b want=0000", u1_Flags); end
    cyc();
    exc_return = 1; valid = 1; Cond = AL; FlagW = 2'b11; ALUFlags = 4'b0110;
    cyc();
    total++; if (u1_Flags !== 4'b1001) begin bad++; $display("FAIL return_wins got=%b want=1001", u1_Flags); end
    total++; if (u1_exec !== 16'd6) begin bad++; $display("FAIL exc_exec got=%0d want=6", u1_exec); end
    ctx_sel = 0; exc_entry = 1; exc_return = 1;
    cyc();
    total++; if (u1_Flags !== 4'b1001) begin bad++; $display("FAIL swap_ctx0 got=%b want=1001", u1_Flags); end
    ctx_sel = 1; exc_return = 1;
    cyc();
    total++; if (u1_Flags !== 4'b0111) begin bad++; $display("FAIL swap_saved got=%b want=0111", u1_Flags); end
    oor = 1; #1;
    total++; if (u2_Flags !== 4'b1001) begin bad++; $display("FAIL oor_ctx0 got=%b want=1001", u2_Flags); end
    oor = 0;
  endtask

  task automatic test_stall_flush();
    valid = 1; Cond = AL; PCS = 1;
    cyc();
    total++; if (u1_PCSrc !== 1'b1) begin bad++; $display("FAIL pcs_live got=%b want=1", u1_PCSrc); end
    total++; if (u1_exec !== 16'd7) begin bad++; $display("FAIL pcs_exec got=%0d want=7", u1_exec); end
    stall = 1; valid = 1; Cond = AL; FlagW = 2'b11; ALUFlags = 4'hF; RegW = 1; exc_return = 1; #1;
    total++; if (u2_RegWrite !== 1'b0) begin bad++; $display("FAIL stall_comb_regwrite got=%b want=0", u2_RegWrite); end
    cyc();
    total++; if ({u1_PCSrc, u1_RegWrite} !== 2'b10) begin bad++; $display("FAIL stall_hold got=%b want=10", {u1_PCSrc, u1_RegWrite}); end
    total++; if (u1_Flags !== 4'b0111) begin bad++; $display("FAIL stall_flags got=%b want=0111", u1_Flags); end
    total++; if ({u1_exec, u1_skip} !== {16'd7, 16'd2}) begin bad++; $display("FAIL stall_cnt got=%0d/%0d want=7/2", u1_exec, u1_skip); end
    flush = 1; valid = 1; Cond = AL; PCS = 1; #1;
    total++; if (u2_PCSrc !== 1'b0) begin bad++; $display("FAIL flush_comb_pcsrc got=%b want=0", u2_PCSrc); end
    cyc();
    total++; if (u1_PCSrc !== 1'b0) begin bad++; $display("FAIL flush_pcsrc got=%b want=0", u1_PCSrc); end
    total++; if ({u1_exec, u1_skip} !== {16'd7, 16'd2}) begin bad++; $display("FAIL flush_cnt got=%0d/%0d want=7/2", u1_exec, u1_skip); end
  endtask

  task automatic test_cond_undef();
    valid = 1; Cond = NV; #1;
    total++; if (u1_CondEx !== 1'b0) begin bad++; $display("FAIL nv_condex got=%b want=0", u1_CondEx); end
    total++; if (u2_cond_undef !== 1'b1) begin bad++; $display("FAIL nv_comb_undef got=%b want=1", u2_cond_undef); end
    cyc();
    total++; if (u1_cond_undef !== 1'b1) begin bad++; $display("FAIL nv_undef got=%b want=1", u1_cond_undef); end
    total++; if (u1_skip !== 16'd3) begin bad++; $display("FAIL nv_skip got=%0d want=3", u1_skip); end
    cyc();
    total++; if (u1_cond_undef !== 1'b0) begin bad++; $display("FAIL nv_undef_clear got=%b want=0", u1_cond_undef); end
  endtask

  task automatic test_back_to_back();
    reset = 0; stall = 1; valid = 1; Cond = AL; FlagW = 2'b11; ALUFlags = 4'hF; exc_return = 1;
    cyc();
    total++; if ({u1_Flags, u1_exec, u1_skip} !== 36'd0) begin
      bad++; $display("FAIL midreset got=%b/%0d/%0d want=0/0/0", u1_Flags, u1_exec, u1_skip);
    end
    total++; if (u2_exec !== 4'd0) begin bad++; $display("FAIL midreset_u2 got=%0d want=0", u2_exec); end
    reset = 1;
    valid = 1; Cond = AL; RegW = 1;
    repeat (15) @(posedge clk);
    #1;
    total++; if (u2_exec !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d want=15", u2_exec); end
    @(posedge clk); #1;
    idle();
    total++; if (u2_exec !== 4'd0) begin bad++; $display("FAIL wrap got=%0d want=0", u2_exec); end
    total++; if (u1_exec !== 16'd16) begin bad++; $display("FAIL wrap_wide got=%0d want=16", u1_exec); end
  endtask

  initial begin
    idle();
    reset = 0; ctx_sel = 0; oor = 0;
    test_reset();
    test_cond_fail();
    test_flag_halves();
    test_half_write();
    test_exception();
    test_stall_flush();
    test_cond_undef();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/condlogic_pipe.md
# condlogic_pipe

Conditional-execution unit for the pipelined ARM-subset processor; replaces the single-cycle condition logic in the Execute stage. It holds `NUM_CTX` banked NZCV flag registers plus one saved-flags register for exception entry/return, and evaluates the 4-bit condition field against the selected context. It gates register, memory, PC and flag writes, optionally through a registered Execute/Memory boundary. It also counts executed versus condition-failed instructions for performance analysis.

## Interface
Parameters:
- `NUM_CTX`, default 2: number of banked flag contexts; must be ≥1.
- `OUT_REG`, default 1: 1 registers the gated outputs one cycle; 0 makes them combinational.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `valid` in 1: an instruction is present in Execute.
- `stall` in 1: freeze flags, counters and output register.
- `flush` in 1: kill the Execute instruction.
- `ctx_sel` in $clog2(NUM_CTX) (min 1): active flag context.
- `Cond` in 4: instruction condition field.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU.
- `FlagW` in 2: bit1 writes {N,Z}; bit0 writes {C,V}.
- `PCS`, `RegW`, `MemW` in 1 each: ungated decoder controls.
- `exc_entry` in 1: save the active context's flags.
- `exc_return` in 1: restore saved flags into the active context.
- `PCSrc`, `RegWrite`, `MemWrite` out 1 each: gated controls.
- `CondEx` out 1: condition result, ungated by `valid`.
- `cond_undef` out 1: `valid` is high and `Cond` = 4'b1111.
- `Flags` out 4: active context flags, registered.
- `exec_cnt`, `skip_cnt` out CNT_W each: performance counters.

## Operation
- Reset (`reset` = 0 at a rising edge) clears all contexts, the saved flags, both counters and the output register to 0.
- Condition decode uses the standard ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. `ge` = (N == V).
- Cond 4'b1111 gives CondEx = 0. It never produces X.
- CondEx is always evaluated against the registered flags of `ctx_sel`. There is no same-cycle forwarding of `ALUFlags`.
- `live` = `valid` & ~`flush` & ~`stall`.
- `go` = `live` & CondEx.
- Gated controls are the decoder control AND `go`.
- FlagWrite[1:0] = `FlagW` & {2{`go`}}.
- Each flag half updates independently at the clock edge from `ALUFlags`.
- `exc_entry` (not gated by `valid`; ignored when `stall`=1): saved ← active context flags, using the pre-update value.
- `exc_return` (ignored when `stall`=1): active context ← saved.
- When `exc_return` and FlagWrite occur in the same cycle, the restore wins.
- When `exc_entry` and `exc_return` occur in the same cycle, both take effect: the flags are swapped.
- Counters:
  - `exec_cnt` increments on `go`.
  - `skip_cnt` increments on `live` & ~CondEx.
  - Both wrap modulo 2^CNT_W.
  - Both hold on `stall` or `flush`.
- `ctx_sel` ≥ NUM_CTX: treated as context 0.

## Timing
- Flag registers, saved flags and counters update on the rising edge following the qualifying cycle. The next instruction sees the new flags.
- OUT_REG=1:
  - `PCSrc`, `RegWrite`, `MemWrite` and `cond_undef` appear one cycle after Execute.
  - The register holds its value during `stall`.
  - When `flush` is high and `stall` is low, the register loads 0.
  - Reset value is 0.
- OUT_REG=0: the same outputs are combinational in the Execute cycle.
- `CondEx` and `Flags` are always same-cycle/registered respectively, regardless of `OUT_REG`.
- Reset in mid-stream overrides `stall`, `flush` and all write requests on that edge.

## Structure
- `cond_pkg` contains:
  - The `cond_e` enum (EQ … AL, NV).
  - Flag index localparams `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - A `flags_t` packed struct {n,z,c,v}.
- One sub-module, `cond_eval`: a purely combinational Cond+Flags→CondEx evaluator, also reused by the branch unit.
- The flag bank is an array of `flags_t` indexed by `ctx_sel`. Counters and the output register live in the top module.

## Test plan
- Reset, then ctx0 flags=0: Cond=EQ with RegW=1, valid=1 → CondEx=0, RegWrite=0 (one cycle later when OUT_REG=1), skip_cnt=1.
- Flag halves: ALUFlags=4'b0100 (Z set), FlagW=2'b10, Cond=AL → Flags=4'b0100 next cycle. A following Cond=EQ, MemW=1 → MemWrite=1, exec_cnt=2.
- Half-write: ALUFlags=4'b1111, FlagW=2'b01 → Flags changes only C and V. A following Cond=GE with N=0, V=1 → CondEx=0.
- Exception flow:
  - Setup: ctx1 flags=4'b1001.
  - Cycle A: `exc_entry` with FlagW=2'b11, ALUFlags=0 → saved=4'b1001, ctx1=0.
  - Cycle B: later `exc_return` with FlagW=2'b11, ALUFlags=4'b0110 → ctx1=4'b1001 (restore wins).
- Stall/flush:
  - `stall`=1 with Cond=AL, FlagW=2'b11 → flags, counters and outputs unchanged.
  - `flush`=1 → PCSrc=0 next cycle, counters unchanged.
- Edge cases:
  - Cond=4'b1111, valid=1 → CondEx=0, cond_undef=1, skip_cnt increments.
  - CNT_W=4: 16 executed instructions → exec_cnt wraps to 0.
